// File: rtl/sqrt_fixed_iter.sv
// Iterative digit-by-digit fixed-point square root with valid/ready handshakes.
// Resolves BITS_PER_CYCLE root bits per clock on the Q-format radicand n << FRAC.
//
//   state | meaning
//   IDLE  | waiting for n; in_ready high
//   CALC  | digit steps in progress, counter counts down from K
//   DONE  | result presented on out_valid until out_ready
module sqrt_fixed_iter #(
  parameter int WIDTH          = 32,
  parameter int FRAC           = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SIGNED         = 1,
  localparam int ROOT_W        = (WIDTH + FRAC) / 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] root,
  output logic [ROOT_W:0]   rem,
  output logic              exact,
  output logic              pos
);

  localparam int K     = ROOT_W / BITS_PER_CYCLE;
  localparam int RAD_W = WIDTH + FRAC;
  localparam int R_W   = ROOT_W + 3;
  localparam int CNT_W = $clog2(K + 1);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bpc
    $error("sqrt_fixed_iter: BITS_PER_CYCLE must be 1 or 2");
  end
  if (ROOT_W % BITS_PER_CYCLE != 0) begin : g_bad_div
    $error("sqrt_fixed_iter: ROOT_W must be divisible by BITS_PER_CYCLE");
  end
  if ((WIDTH % 2 != 0) || (FRAC % 2 != 0) || (FRAC >= WIDTH)) begin : g_bad_fmt
    $error("sqrt_fixed_iter: WIDTH and FRAC must be even with FRAC < WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [RAD_W-1:0]   rad;
  logic [R_W-1:0]     r;
  logic [ROOT_W-1:0]  q;
  logic [CNT_W-1:0]   cnt;

  logic [RAD_W-1:0]   rad_c;
  logic [R_W-1:0]     r_c, rp_c, t_c;
  logic [ROOT_W-1:0]  q_c;
  logic               is_neg, is_zero;

  assign in_ready = (state == IDLE) && !RST;
  assign is_zero  = (n == '0);
  assign is_neg   = (SIGNED != 0) && n[WIDTH-1];

  // r never exceeds 2q, so r<<2|bits fits in ROOT_W+3 bits for every step.
  always_comb begin
    rad_c = rad;
    r_c   = r;
    q_c   = q;
    rp_c  = '0;
    t_c   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rp_c  = {r_c[R_W-3:0], rad_c[RAD_W-1 -: 2]};
      t_c   = {1'b0, q_c, 2'b01};
      if (rp_c >= t_c) begin
        r_c = rp_c - t_c;
        q_c = {q_c[ROOT_W-2:0], 1'b1};
      end else begin
        r_c = rp_c;
        q_c = {q_c[ROOT_W-2:0], 1'b0};
      end
      rad_c = rad_c << 2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rad       <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      root      <= '0;
      rem       <= '0;
      exact     <= 1'b0;
      pos       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rad <= {n, {FRAC{1'b0}}};
            r   <= '0;
            q   <= '0;
            cnt <= CNT_W'(K);
            if (is_zero || is_neg) begin
              state     <= DONE;
              out_valid <= 1'b1;
              root      <= '0;
              rem       <= '0;
              exact     <= is_zero;
              pos       <= !is_neg;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rad <= rad_c;
          r   <= r_c;
          q   <= q_c;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            root      <= q_c;
            rem       <= r_c[ROOT_W:0];
            exact     <= (r_c == '0);
            pos       <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_fixed_iter.sv
// Directed bench for sqrt_fixed_iter: default, two-bits-per-cycle and unsigned
// instances run in lockstep on a shared input stream.
module tb_sqrt_fixed_iter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] n;

  logic        ir_a, ir_b, ir_c;
  logic        ov_a, ov_b, ov_c;
  logic [23:0] root_a, root_b, root_c;
  logic [24:0] rem_a, rem_b, rem_c;
  logic        ex_a, ex_b, ex_c;
  logic        pos_a, pos_b, pos_c;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  sqrt_fixed_iter u_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_a), .n(n),
    .out_valid(ov_a), .out_ready(out_ready), .root(root_a), .rem(rem_a),
    .exact(ex_a), .pos(pos_a));

  sqrt_fixed_iter #(.BITS_PER_CYCLE(2)) u_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_b), .n(n),
    .out_valid(ov_b), .out_ready(out_ready), .root(root_b), .rem(rem_b),
    .exact(ex_b), .pos(pos_b));

  sqrt_fixed_iter #(.SIGNED(0)) u_c (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_c), .n(n),
    .out_valid(ov_c), .out_ready(out_ready), .root(root_c), .rem(rem_c),
    .exact(ex_c), .pos(pos_c));

  typedef struct {
    logic [31:0] n;
    logic        sc;      // shortcut for the signed instances
    logic [23:0] root;
    logic [24:0] rem;
    logic        exact;
    logic        pos;
    logic [23:0] croot;   // unsigned instance expectations
    logic [24:0] crem;
    logic        cexact;
    logic        cpos;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk("consume_ov", {ov_a, ov_b, ov_c}, 3'b000);
    chk("consume_ir", {ir_a, ir_b, ir_c}, 3'b111);
  endtask

  task automatic run_vec(input vec_t v);
    int la, lb, lc;
    int ea, eb, ec;
    la = -1; lb = -1; lc = -1;
    n = v.n;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = $urandom;
    for (int e = 1; e <= 40; e++) begin
      if (ov_a && la < 0) la = e;
      if (ov_b && lb < 0) lb = e;
      if (ov_c && lc < 0) lc = e;
      if (la >= 0 && lb >= 0 && lc >= 0) break;
      @(posedge CLK); #1;
    end
    ea = v.sc ? 1 : 25;
    eb = v.sc ? 1 : 13;
    ec = (v.n == 32'd0) ? 1 : 25;
    chk($sformatf("lat_a n=%h", v.n), 64'(la), 64'(ea));
    chk($sformatf("lat_b n=%h", v.n), 64'(lb), 64'(eb));
    chk($sformatf("lat_c n=%h", v.n), 64'(lc), 64'(ec));
    chk($sformatf("res_a n=%h", v.n), {root_a, rem_a, ex_a, pos_a}, {v.root, v.rem, v.exact, v.pos});
    chk($sformatf("res_b n=%h", v.n), {root_b, rem_b, ex_b, pos_b}, {v.root, v.rem, v.exact, v.pos});
    chk($sformatf("res_c n=%h", v.n), {root_c, rem_c, ex_c, pos_c}, {v.croot, v.crem, v.cexact, v.cpos});
    consume();
  endtask

  initial begin
    vecs[0] = '{32'h00040000, 0, 24'h020000, 25'd0,      1, 1, 24'h020000, 25'd0,        1, 1};
    vecs[1] = '{32'h00020000, 0, 24'h016A09, 25'd166831, 0, 1, 24'h016A09, 25'd166831,   0, 1};
    vecs[2] = '{32'h00004000, 0, 24'h008000, 25'd0,      1, 1, 24'h008000, 25'd0,        1, 1};
    vecs[3] = '{32'h00000000, 1, 24'h000000, 25'd0,      1, 1, 24'h000000, 25'd0,        1, 1};
    vecs[4] = '{32'hFFFFFFFF, 1, 24'h000000, 25'd0,      0, 0, 24'hFFFFFF, 25'd33488895, 0, 1};
    vecs[5] = '{32'h00090000, 0, 24'h030000, 25'd0,      1, 1, 24'h030000, 25'd0,        1, 1};
    vecs[6] = '{32'h00000001, 0, 24'h000100, 25'd0,      1, 1, 24'h000100, 25'd0,        1, 1};
    vecs[7] = '{32'h00030000, 0, 24'h01BB67, 25'd154767, 0, 1, 24'h01BB67, 25'd154767,   0, 1};
    vecs[8] = '{32'h7FFFFFFF, 0, 24'hB504F3, 25'd4751703,0, 1, 24'hB504F3, 25'd4751703,  0, 1};
    vecs[9] = '{32'h80000000, 1, 24'h000000, 25'd0,      0, 0, 24'hB504F3, 25'd4817239,  0, 1};

    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; n = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ir", {ir_a, ir_b, ir_c}, 3'b000);
    chk("rst_ov", {ov_a, ov_b, ov_c}, 3'b000);
    chk("rst_out_a", {root_a, rem_a, ex_a, pos_a}, 51'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_ir", {ir_a, ir_b, ir_c}, 3'b111);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: result held while out_ready stays low, input ignored.
    n = 32'h00020000; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    chk("bp_valid", ov_a, 1'b1);
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid;
      n = $urandom;
      @(posedge CLK); #1;
      chk($sformatf("bp_hold_%0d", c), {ov_a, ir_a, root_a, rem_a, ex_a, pos_a},
          {1'b1, 1'b0, 24'h016A09, 25'd166831, 1'b0, 1'b1});
    end
    in_valid = 1'b0;
    consume();

    // Result consumed with in_valid high: input is taken only on a later IDLE edge.
    n = 32'h00040000; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    n = 32'h00090000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk("both_ov", ov_a, 1'b0);
    chk("both_idle", ir_a, 1'b1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("both_accept", ir_a, 1'b0);
    begin
      int lat;
      lat = -1;
      for (int e = 1; e <= 40; e++) begin
        if (ov_a) begin lat = e; break; end
        @(posedge CLK); #1;
      end
      chk("both_lat", 64'(lat), 64'd25);
      chk("both_root", root_a, 24'h030000);
    end
    repeat (20) @(posedge CLK);
    #1;
    consume();

    // Reset during CALC aborts the result.
    n = 32'h00020000; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("midrst_ir", {ir_a, ir_b, ir_c}, 3'b000);
    @(posedge CLK); #1;
    RST = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (ov_a || ov_b || ov_c) seen = 1'b1;
        @(posedge CLK); #1;
      end
      chk("midrst_no_valid", seen, 1'b0);
    end
    chk("midrst_idle", {ir_a, ir_b, ir_c}, 3'b111);
    run_vec(vecs[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
